// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: fetch-side instruction queue with JAL, overflow-replay and execute redirects (BTFN_PREDICT_EN adds backward-branch prediction)
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instr,
  output logic        is_branch_taken,
  output logic [31:0] branch_pc,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_pred_taken
);
  logic [31:0] pc_q [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic [DEPTH-1:0] pt_q;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0] count;
  logic is_jal, pred, pop, can_push, push, drop;
  logic [31:0] imm_j, imm_b, target;
  always_comb begin
    is_jal = fetch_instr[6:0] == 7'b1101111;
    imm_j = {{12{fetch_instr[31]}}, fetch_instr[19:12], fetch_instr[20], fetch_instr[30:21], 1'b0};
    imm_b = {{20{fetch_instr[31]}}, fetch_instr[7], fetch_instr[30:25], fetch_instr[11:8], 1'b0};
`ifdef BTFN_PREDICT_EN
    pred = is_jal || (fetch_instr[6:0] == 7'b1100011 && fetch_instr[31]);
`else
    pred = is_jal;
`endif
    target = fetch_pc + (is_jal ? imm_j : imm_b);
    pop = out_valid && out_ready && !ex_redirect;
    can_push = count != (PTR_W+1)'(DEPTH) || pop;
    push = !is_branch_taken && !ex_redirect && can_push;
    drop = !is_branch_taken && !ex_redirect && !can_push;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr] <= fetch_pc;
      instr_q[wr_ptr] <= fetch_instr;
      pt_q[wr_ptr] <= pred;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      is_branch_taken <= 1'b0;
      branch_pc <= '0;
    end else if (ex_redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      is_branch_taken <= 1'b1;
      branch_pc <= ex_redirect_pc;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      is_branch_taken <= drop || (push && pred);
      branch_pc <= drop ? fetch_pc : (push && pred) ? target : branch_pc;
    end
  end
  always_comb begin
    out_valid = count != '0;
    out_pc = out_valid ? pc_q[rd_ptr] : '0;
    out_instr = out_valid ? instr_q[rd_ptr] : '0;
    out_pred_taken = out_valid && pt_q[rd_ptr];
  end
endmodule
